// File: rtl/pong_pkg.sv
// Shared constants and types for the pong ball motion logic.
package pong_pkg;

    localparam int unsigned H_TOTAL = 455;
    localparam logic [8:0]  SERVE_X = 9'd300;
    localparam int unsigned BALL_W  = 4;

    localparam logic [1:0] MOT_STOP  = 2'b01;
    localparam logic [1:0] MOT_LEFT  = 2'b11;
    localparam logic [1:0] MOT_RIGHT = 2'b10;

    localparam logic [3:0] HITS_MED  = 4'd4;
    localparam logic [3:0] HITS_FAST = 4'd12;

    typedef logic [1:0] speed_t;

    function automatic speed_t speed_for_hits(input logic [3:0] hits);
        if (hits >= HITS_FAST) begin
            return speed_t'(2'd3);
        end else if (hits >= HITS_MED) begin
            return speed_t'(2'd2);
        end
        return speed_t'(2'd1);
    endfunction

endpackage

// File: rtl/ball_speed_counter.sv
// Paddle-hit counter and speed decode; only built with BALL_HMOTION_SPEEDUP_EN defined.
`ifdef BALL_HMOTION_SPEEDUP_EN
module ball_speed_counter
    import pong_pkg::*;
(
    input  logic   clk,
    input  logic   _reset,
    input  logic   ce,
    input  logic   _hit,
    input  logic   serve,
    input  logic   attract,
    output speed_t speed
);

    logic [3:0] hit_cnt_q, hit_cnt_d;
    speed_t     speed_q, speed_d;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        // Serve and attract both win over a coincident hit.
        if (serve || attract) begin
            hit_cnt_d = 4'd0;
        end else if (!_hit && (hit_cnt_q != 4'hf)) begin
            hit_cnt_d = hit_cnt_q + 4'd1;
        end
        speed_d = speed_for_hits(hit_cnt_d);
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            hit_cnt_q <= 4'd0;
            speed_q   <= speed_t'(2'd1);
        end else if (ce) begin
            hit_cnt_q <= hit_cnt_d;
            speed_q   <= speed_d;
        end
    end

    assign speed = speed_q;

endmodule
`endif

// File: rtl/ball_horizontal_motion.sv
// Ball horizontal position, per-frame stepping and registered ball video window.
// Hit-driven speed-up is enabled by defining BALL_HMOTION_SPEEDUP_EN; otherwise speed is 1.
module ball_horizontal_motion
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       _reset,
    input  logic       ce,
    input  logic [8:0] hcnt,
    input  logic       vreset,
    input  logic       aa,
    input  logic       ba,
    input  logic       _hit,
    input  logic       serve,
    input  logic       attract,
    output logic [8:0] ball_x,
    output speed_t     speed,
    output logic       hvid
);

    localparam logic [9:0] HTOT10 = 10'(H_TOTAL);
    localparam logic [9:0] BALLW10 = 10'(BALL_W);

    logic [8:0] ball_x_q, ball_x_d, pos_next;
    logic       hvid_q, hvid_d;
    logic [9:0] sum, dif, off;

`ifdef BALL_HMOTION_SPEEDUP_EN
    ball_speed_counter u_speed (
        .clk     (clk),
        ._reset  (_reset),
        .ce      (ce),
        ._hit    (_hit),
        .serve   (serve),
        .attract (attract),
        .speed   (speed)
    );
`else
    logic unused_inputs;
    assign unused_inputs = ^{_hit, attract};
    assign speed = speed_t'(2'd1);
`endif

    always_comb begin
        // 10-bit arithmetic; a borrow shows up in bit 9 and is folded back by +H_TOTAL.
        sum = {1'b0, ball_x_q} + {8'd0, speed};
        if (sum >= HTOT10) begin
            sum = sum - HTOT10;
        end
        dif = {1'b0, ball_x_q} - {8'd0, speed};
        if (dif[9]) begin
            dif = dif + HTOT10;
        end

        case ({aa, ba})
            MOT_RIGHT: pos_next = sum[8:0];
            MOT_LEFT:  pos_next = dif[8:0];
            default:   pos_next = ball_x_q;
        endcase

        ball_x_d = ball_x_q;
        if (serve) begin
            ball_x_d = SERVE_X;
        end else if (vreset) begin
            ball_x_d = pos_next;
        end

        off = {1'b0, hcnt} - {1'b0, ball_x_q};
        if (off[9]) begin
            off = off + HTOT10;
        end
        hvid_d = (off < BALLW10);
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            ball_x_q <= SERVE_X;
            hvid_q   <= 1'b0;
        end else if (ce) begin
            ball_x_q <= ball_x_d;
            hvid_q   <= hvid_d;
        end
    end

    assign ball_x = ball_x_q;
    assign hvid   = hvid_q;

endmodule

// File: tb/tb_ball_horizontal_motion.sv
// Directed bench for ball_horizontal_motion; expectations follow BALL_HMOTION_SPEEDUP_EN.
module tb_ball_horizontal_motion;

    logic       clk = 1'b0;
    logic       _reset;
    logic       ce;
    logic [8:0] hcnt;
    logic       vreset;
    logic       aa;
    logic       ba;
    logic       _hit;
    logic       serve;
    logic       attract;
    logic [8:0] ball_x;
    logic [1:0] speed;
    logic       hvid;

    int checks = 0;
    int errors = 0;

`ifdef BALL_HMOTION_SPEEDUP_EN
    localparam int SP_MED  = 2;
    localparam int SP_FAST = 3;
`else
    localparam int SP_MED  = 1;
    localparam int SP_FAST = 1;
`endif

    always #5 clk = ~clk;

    ball_horizontal_motion dut (
        .clk     (clk),
        ._reset  (_reset),
        .ce      (ce),
        .hcnt    (hcnt),
        .vreset  (vreset),
        .aa      (aa),
        .ba      (ba),
        ._hit    (_hit),
        .serve   (serve),
        .attract (attract),
        .ball_x  (ball_x),
        .speed   (speed),
        .hvid    (hvid)
    );

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vstep(input logic [1:0] m);
        {aa, ba} = m;
        vreset = 1'b1;
        tick();
        vreset = 1'b0;
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            _hit = 1'b0;
            tick();
            _hit = 1'b1;
        end
    endtask

    function automatic logic hvid_exp(input int h);
        return (h >= 453) || (h <= 1);
    endfunction

    initial begin
        _reset = 1'b0; ce = 1'b1; hcnt = 9'd0; vreset = 1'b0;
        {aa, ba} = 2'b01; _hit = 1'b1; serve = 1'b0; attract = 1'b0;
        tick(); tick();
        check("rst_ball_x", 10'(ball_x), 10'd300);
        check("rst_speed", 10'(speed), 10'd1);
        check("rst_hvid", 10'(hvid), 10'd0);
        _reset = 1'b1;
        tick();

        // Right three frames, no motion between vresets
        vstep(2'b10);
        check("right_1", 10'(ball_x), 10'd301);
        tick(); tick();
        check("no_vreset_hold", 10'(ball_x), 10'd301);
        vstep(2'b10);
        vstep(2'b10);
        check("right_3", 10'(ball_x), 10'd303);
        check("right_speed", 10'(speed), 10'd1);

        // Walk left down to 1, then wrap
        for (int i = 0; i < 302; i++) vstep(2'b11);
        check("left_to_1", 10'(ball_x), 10'd1);
        hits(4);
        check("speed_after_4", 10'(speed), 10'(SP_MED));
`ifdef BALL_HMOTION_SPEEDUP_EN
        vstep(2'b11);
`else
        vstep(2'b11);
        check("left_to_0", 10'(ball_x), 10'd0);
        vstep(2'b11);
`endif
        check("left_wrap", 10'(ball_x), 10'd454);
        vstep(2'b01);
        check("stop_01", 10'(ball_x), 10'd454);
        vstep(2'b00);
        check("stop_00", 10'(ball_x), 10'd454);

        // Hit count thresholds and saturation
        hits(7);
        check("speed_cnt11", 10'(speed), 10'(SP_MED));
        hits(1);
        check("speed_cnt12", 10'(speed), 10'(SP_FAST));
        hits(10);
        check("speed_sat", 10'(speed), 10'(SP_FAST));

        serve = 1'b1; tick(); serve = 1'b0;
        check("serve_ball_x", 10'(ball_x), 10'd300);
        check("serve_speed", 10'(speed), 10'd1);

        // Count=3 at ball 100, then hit+vreset together moving right
        hits(3);
        check("speed_cnt3", 10'(speed), 10'd1);
        for (int i = 0; i < 200; i++) vstep(2'b11);
        check("left_to_100", 10'(ball_x), 10'd100);
        {aa, ba} = 2'b10; _hit = 1'b0; vreset = 1'b1;
        tick();
        _hit = 1'b1; vreset = 1'b0;
        check("hit_vreset_x", 10'(ball_x), 10'd101);
        check("hit_vreset_speed", 10'(speed), 10'(SP_MED));

        // Serve beats a same-cycle vreset and hit
        hits(3);
        check("speed_cnt7", 10'(speed), 10'(SP_MED));
        {aa, ba} = 2'b10; serve = 1'b1; vreset = 1'b1; _hit = 1'b0;
        tick();
        serve = 1'b0; vreset = 1'b0; _hit = 1'b1;
        check("serve_vreset_x", 10'(ball_x), 10'd300);
        check("serve_vreset_speed", 10'(speed), 10'd1);
        hits(3);
        check("serve_beats_hit", 10'(speed), 10'd1);
        hits(1);
        check("speed_cnt4_again", 10'(speed), 10'(SP_MED));

        // Attract clears count and holds speed at 1; motion continues
        attract = 1'b1;
        tick();
        check("attract_clear", 10'(speed), 10'd1);
        hits(5);
        check("attract_hits", 10'(speed), 10'd1);
        vstep(2'b10);
        check("attract_move", 10'(ball_x), 10'd301);
        attract = 1'b0;
        serve = 1'b1; tick(); serve = 1'b0;
        check("serve2_ball_x", 10'(ball_x), 10'd300);

        for (int i = 0; i < 153; i++) vstep(2'b10);
        check("right_to_453", 10'(ball_x), 10'd453);

        // hvid window sweep, one clock of latency
        hcnt = 9'd0;
        tick();
        for (int h = 0; h < 455; h++) begin
            hcnt = 9'(h);
            #1;
            check("hvid_pre_edge", 10'(hvid), 10'(hvid_exp(h == 0 ? 0 : h - 1)));
            tick();
            check("hvid_sweep", 10'(hvid), 10'(hvid_exp(h)));
        end

        // ce low freezes everything
        ce = 1'b0; hcnt = 9'd100; {aa, ba} = 2'b10; vreset = 1'b1;
        tick(); tick();
        check("ce_hold_hvid", 10'(hvid), 10'd1);
        check("ce_hold_x", 10'(ball_x), 10'd453);
        vreset = 1'b0; ce = 1'b1;
        tick();
        check("ce_resume_hvid", 10'(hvid), 10'd0);

        // Asynchronous reset mid-frame
        vstep(2'b10);
        check("pre_reset_x", 10'(ball_x), 10'd454);
        hcnt = 9'd0;
        tick();
        check("pre_reset_hvid", 10'(hvid), 10'd1);
        #2;
        _reset = 1'b0;
        #1;
        check("async_rst_x", 10'(ball_x), 10'd300);
        check("async_rst_hvid", 10'(hvid), 10'd0);
        check("async_rst_speed", 10'(speed), 10'd1);
        tick(); tick();
        _reset = 1'b1;
        {aa, ba} = 2'b10;
        tick(); tick(); tick();
        check("post_rst_hold", 10'(ball_x), 10'd300);
        vstep(2'b10);
        check("post_rst_step", 10'(ball_x), 10'd301);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
